// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, execute redirect,
// and the decode-side instruction handshake.
interface fetch_if #(
  parameter int Width = 32
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [Width-1:0] imem_addr;
  logic             imem_resp_valid;
  logic [Width-1:0] imem_resp_data;
  logic             redirect_valid;
  logic [Width-1:0] redirect_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic [Width-1:0] inst;
  logic [Width-1:0] inst_pc;
  logic [31:0]      fetch_count;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_count,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_count,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word at a time, holds it
// for decode, and discards in-flight responses when execute redirects the pc.
module fetch_unit #(
  parameter int               Width    = 32,
  parameter logic [Width-1:0] RESET_PC = '0
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } state_e;

  localparam logic [Width-1:0] NOP = Width'(32'h0000_0013);

  state_e           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic [Width-1:0] inst_q, inst_d;
  logic [Width-1:0] inst_pc_q, inst_pc_d;
  logic             inst_valid_q, inst_valid_d;
  logic [31:0]      fetch_count_q, fetch_count_d;

  function automatic logic [Width-1:0] align_pc(input logic [Width-1:0] a);
    return {a[Width-1:2], 2'b00};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      inst_q        <= NOP;
      inst_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.redirect_valid) begin
          pc_d = align_pc(bus.redirect_pc);
        end else if (bus.imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A redirect racing the response kills it; otherwise DRAIN eats it later.
        if (bus.redirect_valid) begin
          pc_d    = align_pc(bus.redirect_pc);
          state_d = bus.imem_resp_valid ? ST_FETCH : ST_DRAIN;
        end else if (bus.imem_resp_valid) begin
          inst_d       = bus.imem_resp_data;
          inst_pc_d    = pc_q;
          pc_d         = pc_q + Width'(4);
          inst_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.redirect_valid) begin
          pc_d         = align_pc(bus.redirect_pc);
          inst_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end else if (bus.inst_ready) begin
          inst_valid_d  = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (bus.redirect_valid) begin
          pc_d = align_pc(bus.redirect_pc);
        end
        if (bus.imem_resp_valid) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Request is combinational so the first fetch goes out in the cycle after release.
  assign bus.imem_req_valid = rst_n && (state_q == ST_FETCH) && !bus.redirect_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.fetch_count    = fetch_count_q;

endmodule
